// File: rtl/approx_mon_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
package approx_mon_pkg;

  localparam int OPW = 8;
  localparam int PW  = 2 * OPW;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } monState_e;

  // Accumulator widths sized so 2^cntW-1 samples at maximum ED cannot overflow.
  function automatic int sumEdWidth(input int cntW);
    return PW + cntW;
  endfunction

  function automatic int sumSqWidth(input int cntW);
    return 2 * PW + cntW;
  endfunction

endpackage

// File: rtl/approx_op_delay.sv
// LAT-stage shift register aligning {valid, operands} with the multiplier output.
module approx_op_delay #(
  parameter int LAT = 1,
  parameter int DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic [LAT-1:0] valid_q;
  logic [DW-1:0]  data_q [LAT];

  // Flush kills every valid bit, including the one loaded on the flush edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i & ~flush_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush_i;
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/approx_err_monitor.sv
// Error-distance statistics collector for 8x8 approximate multipliers.
// Optional squared-ED accumulator enabled by defining APPROX_ERR_MON_SQ_EN.
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      n_samples,
  input  logic                  in_valid,
  input  logic [OPW-1:0]        x,
  input  logic [OPW-1:0]        y,
  input  logic [PW-1:0]         p_approx,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [PW+CNT_W-1:0]   sum_ed,
  output logic [PW-1:0]         max_ed
`ifdef APPROX_ERR_MON_SQ_EN
  ,
  output logic [2*PW+CNT_W-1:0] sum_sq_ed
`endif
);

  localparam int SUM_W = sumEdWidth(CNT_W);

  monState_e        state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;
  logic [SUM_W-1:0] sumEd_q, sumEd_d;
  logic [PW-1:0]    maxEd_q, maxEd_d;
  logic             done_q, done_d;
  logic             flush;

  logic             validD;
  logic [2*OPW-1:0] opsD;
  logic [PW-1:0]    exact;
  logic [PW:0]      diff;
  logic [PW-1:0]    ed;

`ifdef APPROX_ERR_MON_SQ_EN
  localparam int SQ_W = sumSqWidth(CNT_W);
  logic [SQ_W-1:0] sumSq_q, sumSq_d;
  logic [2*PW-1:0] edSq;
`endif

  approx_op_delay #(
    .LAT (LAT),
    .DW  (2 * OPW)
  ) uOpDelay (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .valid_i (in_valid),
    .data_i  ({x, y}),
    .valid_o (validD),
    .data_o  (opsD)
  );

  // Signed difference carries one extra bit; magnitude always fits in PW bits.
  assign exact = PW'(opsD[2*OPW-1:OPW]) * PW'(opsD[OPW-1:0]);
  assign diff  = {1'b0, exact} - {1'b0, p_approx};
  assign ed    = diff[PW] ? (~diff[PW-1:0] + PW'(1)) : diff[PW-1:0];

`ifdef APPROX_ERR_MON_SQ_EN
  assign edSq = {{PW{1'b0}}, ed} * {{PW{1'b0}}, ed};
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    sampleCnt_d = sampleCnt_q;
    errCnt_d    = errCnt_q;
    sumEd_d     = sumEd_q;
    maxEd_d     = maxEd_q;
    done_d      = 1'b0;
    flush       = 1'b0;
`ifdef APPROX_ERR_MON_SQ_EN
    sumSq_d     = sumSq_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          flush       = 1'b1;
          n_d         = n_samples;
          sampleCnt_d = '0;
          errCnt_d    = '0;
          sumEd_d     = '0;
          maxEd_d     = '0;
`ifdef APPROX_ERR_MON_SQ_EN
          sumSq_d     = '0;
`endif
          if (n_samples == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      // start is deliberately not examined here: a run cannot be restarted.
      RUN: begin
        if (validD && (sampleCnt_q < n_q)) begin
          sampleCnt_d = sampleCnt_q + CNT_W'(1);
          sumEd_d     = sumEd_q + SUM_W'(ed);
          if (ed != '0) begin
            errCnt_d = errCnt_q + CNT_W'(1);
          end
          if (ed > maxEd_q) begin
            maxEd_d = ed;
          end
`ifdef APPROX_ERR_MON_SQ_EN
          sumSq_d = sumSq_q + SQ_W'(edSq);
`endif
          if (sampleCnt_d == n_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      sampleCnt_q <= '0;
      errCnt_q    <= '0;
      sumEd_q     <= '0;
      maxEd_q     <= '0;
      done_q      <= 1'b0;
`ifdef APPROX_ERR_MON_SQ_EN
      sumSq_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      sampleCnt_q <= sampleCnt_d;
      errCnt_q    <= errCnt_d;
      sumEd_q     <= sumEd_d;
      maxEd_q     <= maxEd_d;
      done_q      <= done_d;
`ifdef APPROX_ERR_MON_SQ_EN
      sumSq_q     <= sumSq_d;
`endif
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign sample_cnt = sampleCnt_q;
  assign err_cnt    = errCnt_q;
  assign sum_ed     = sumEd_q;
  assign max_ed     = maxEd_q;
`ifdef APPROX_ERR_MON_SQ_EN
  assign sum_sq_ed  = sumSq_q;
`endif

endmodule
